ldm_stm_sequencer: RTL and testbench

LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

---
 rtl/arm1_pkg.sv | 20 ++
 rtl/lowest_bit_encoder.sv | 31 +++
 rtl/ldm_stm_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm1_pkg.sv
// ---------------------------------------------------------------------------
// arm1_pkg
// Shared definitions for the LDM/STM register-list sequencer: default widths
// of the register list and register number, transfer-index width, and the
// sequencer state encoding.
// ---------------------------------------------------------------------------
package arm1_pkg;

  localparam int LIST_W_DEF = 16;
  localparam int NB_W_DEF   = 4;
  localparam int IDX_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_WBACK = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage : arm1_pkg

// File: rtl/lowest_bit_encoder.sv
// ---------------------------------------------------------------------------
// lowest_bit_encoder
// Combinational priority encoder for the pending register mask.
// Ports:
//   mask_i    - pending register mask (bit n selects rn)
//   idx_o     - index of the lowest set bit (0 when mask is empty)
//   one_hot_o - exactly one bit of mask_i is set
// ---------------------------------------------------------------------------
module lowest_bit_encoder #(
  parameter int LIST_W = 16,
  parameter int NB_W   = 4
) (
  input  logic [LIST_W-1:0] mask_i,
  output logic [NB_W-1:0]   idx_o,
  output logic              one_hot_o
);

  localparam logic [LIST_W-1:0] ONE = {{(LIST_W-1){1'b0}}, 1'b1};

  // Scan from the top down so the lowest set bit is the final value written.
  always_comb begin
    idx_o = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      idx_o = mask_i[i] ? i[NB_W-1:0] : idx_o;
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit mask.
  assign one_hot_o = (mask_i != '0) && ((mask_i & (mask_i - ONE)) == '0);

endmodule : lowest_bit_encoder

// File: rtl/ldm_stm_sequencer.sv
// ---------------------------------------------------------------------------
// ldm_stm_sequencer
// Walks an LDM/STM register list lowest register first, presenting one
// register number per accepted memory transfer, optionally followed by a
// base-register writeback slot and a one-cycle completion pulse.
// Optional feature macro: LDM_WRITEBACK_EN (enables the WBACK slot; without
// it wb_req is ignored and wb_valid stays 0).
// Ports:
//   phi1_clock, nreset           - clock, asynchronous active-low reset
//   start, reg_list, base_nb,    - block-transfer request and its operands,
//   wb_req, s_bit                  latched when accepted in IDLE
//   mem_ready, abort             - transfer accepted / data abort
//   busy, reg_valid, reg_nb,     - sequence status and current register
//   first, last, xfer_idx          with its position in the list
//   force_mode                   - user-bank select for the register decoder
//   wb_valid, done               - writeback slot, completion pulse
// ---------------------------------------------------------------------------
module ldm_stm_sequencer
  import arm1_pkg::*;
#(
  parameter int LIST_W = LIST_W_DEF,
  parameter int NB_W   = NB_W_DEF
) (
  input  logic              phi1_clock,
  input  logic              nreset,
  input  logic              start,
  input  logic [LIST_W-1:0] reg_list,
  input  logic [NB_W-1:0]   base_nb,
  input  logic              wb_req,
  input  logic              s_bit,
  input  logic              mem_ready,
  input  logic              abort,
  output logic              busy,
  output logic              reg_valid,
  output logic [NB_W-1:0]   reg_nb,
  output logic              first,
  output logic              last,
  output logic [IDX_W-1:0]  xfer_idx,
  output logic              force_mode,
  output logic              wb_valid,
  output logic              done
);

  localparam logic [LIST_W-1:0] ONE      = {{(LIST_W-1){1'b0}}, 1'b1};
  // An empty list still moves one register: r15.
  localparam logic [LIST_W-1:0] R15_MASK = ONE << 15;

  seq_state_e        state_q, state_d;
  logic [LIST_W-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NB_W-1:0]   base_q, base_d;
  logic              wb_q, wb_d;
  logic              s_q, s_d;

  logic [NB_W-1:0]   low_idx_s;
  logic              one_hot_s;
  logic              wb_req_s;

`ifdef LDM_WRITEBACK_EN
  assign wb_req_s = wb_req;
`else
  // Writeback disabled: wb_q is latched as 0, so WBACK is never entered.
  logic unused_wb_req_s;
  assign unused_wb_req_s = wb_req;
  assign wb_req_s        = 1'b0;
`endif

  lowest_bit_encoder #(
    .LIST_W (LIST_W),
    .NB_W   (NB_W)
  ) u_enc (
    .mask_i    (pending_q),
    .idx_o     (low_idx_s),
    .one_hot_o (one_hot_s)
  );

  // State and operand registers.
  always_ff @(posedge phi1_clock or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      wb_q      <= 1'b0;
      s_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      wb_q      <= wb_d;
      s_q       <= s_d;
    end
  end

  // Next-state logic; abort takes priority over mem_ready.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    base_d    = base_q;
    wb_d      = wb_q;
    s_d       = s_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_XFER;
          pending_d = (reg_list == '0) ? R15_MASK : reg_list;
          idx_d     = 5'd0;
          base_d    = base_nb;
          wb_d      = wb_req_s;
          s_d       = s_bit;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (abort) begin
          state_d   = ST_IDLE;
          pending_d = '0;
          idx_d     = 5'd0;
          wb_d      = 1'b0;
          s_d       = 1'b0;
        end else if (mem_ready) begin
          pending_d = pending_q & (pending_q - ONE);
          idx_d     = idx_q + 5'd1;
          if (one_hot_s) begin
            state_d = wb_q ? ST_WBACK : ST_DONE;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d   = ST_XFER;
        end
      end
      ST_WBACK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
        pending_d = '0;
        idx_d     = (abort) ? 5'd0 : idx_q;
        wb_d      = 1'b0;
        s_d       = (abort) ? 1'b0 : s_q;
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        pending_d = '0;
        idx_d     = 5'd0;
        wb_d      = 1'b0;
        s_d       = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = '0;
        idx_d     = 5'd0;
        wb_d      = 1'b0;
        s_d       = 1'b0;
      end
    endcase
  end

  // Outputs decoded from registered state only, so they clear with nreset.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    reg_valid  = (state_q == ST_XFER);
    first      = (state_q == ST_XFER) && (idx_q == 5'd0);
    last       = (state_q == ST_XFER) && one_hot_s;
    xfer_idx   = idx_q;
    force_mode = (state_q != ST_IDLE) ? s_q : 1'b0;
    done       = (state_q == ST_DONE);
`ifdef LDM_WRITEBACK_EN
    wb_valid   = (state_q == ST_WBACK);
`else
    wb_valid   = 1'b0;
`endif
    case (state_q)
      ST_XFER:  reg_nb = low_idx_s;
      ST_WBACK: reg_nb = base_q;
      default:  reg_nb = '0;
    endcase
  end

endmodule : ldm_stm_sequencer

// File: tb/tb_ldm_stm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ldm_stm_sequencer
// Directed self-checking bench for ldm_stm_sequencer. Expected register
// numbers come from a bench-side list model pushed into a queue at start
// and popped as each transfer is accepted.
// ---------------------------------------------------------------------------
module tb_ldm_stm_sequencer;

  logic        phi1_clock = 1'b0;
  logic        nreset;
  logic        start;
  logic [15:0] reg_list;
  logic [3:0]  base_nb;
  logic        wb_req;
  logic        s_bit;
  logic        mem_ready;
  logic        abort;
  logic        busy;
  logic        reg_valid;
  logic [3:0]  reg_nb;
  logic        first;
  logic        last;
  logic [4:0]  xfer_idx;
  logic        force_mode;
  logic        wb_valid;
  logic        done;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  ldm_stm_sequencer dut (
    .phi1_clock (phi1_clock),
    .nreset     (nreset),
    .start      (start),
    .reg_list   (reg_list),
    .base_nb    (base_nb),
    .wb_req     (wb_req),
    .s_bit      (s_bit),
    .mem_ready  (mem_ready),
    .abort      (abort),
    .busy       (busy),
    .reg_valid  (reg_valid),
    .reg_nb     (reg_nb),
    .first      (first),
    .last       (last),
    .xfer_idx   (xfer_idx),
    .force_mode (force_mode),
    .wb_valid   (wb_valid),
    .done       (done)
  );

  always #5 phi1_clock = ~phi1_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge phi1_clock);
    #1;
  endtask

  task automatic push_model(input logic [15:0] mask);
    if (mask == 16'h0000) begin
      exp_q.push_back(15);
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (mask[i]) exp_q.push_back(i);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_reg_valid"},  32'(reg_valid),  32'd0);
    chk({tag, "_reg_nb"},     32'(reg_nb),     32'd0);
    chk({tag, "_first"},      32'(first),      32'd0);
    chk({tag, "_last"},       32'(last),       32'd0);
    chk({tag, "_xfer_idx"},   32'(xfer_idx),   32'd0);
    chk({tag, "_force_mode"}, 32'(force_mode), 32'd0);
    chk({tag, "_wb_valid"},   32'(wb_valid),   32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
  endtask

  task automatic do_start(input logic [15:0] mask, input logic [3:0] base,
                          input logic wb, input logic s);
    chk("idle_before_start", 32'(busy), 32'd0);
    reg_list = mask;
    base_nb  = base;
    wb_req   = wb;
    s_bit    = s;
    start    = 1'b1;
    push_model(mask);
    tick();
    start    = 1'b0;
    reg_list = 16'h0000;
    base_nb  = 4'h0;
    wb_req   = 1'b0;
    s_bit    = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Compare every XFER cycle against the queue head; stall the first transfer.
  task automatic drain(input int stall, input logic s_exp, output int hold0);
    int k;
    int cyc;
    k     = 0;
    cyc   = 0;
    hold0 = 0;
    while (exp_q.size() > 0 && cyc < 64) begin
      chk("reg_valid",  32'(reg_valid),  32'd1);
      chk("reg_nb",     32'(reg_nb),     32'(exp_q[0]));
      chk("first",      32'(first),      32'(k == 0));
      chk("last",       32'(last),       32'(exp_q.size() == 1));
      chk("xfer_idx",   32'(xfer_idx),   32'(k));
      chk("force_mode", 32'(force_mode), 32'(s_exp));
      chk("wb_valid_x", 32'(wb_valid),   32'd0);
      if (k == 0) hold0++;
      mem_ready = !((k == 0) && (hold0 <= stall));
      if (mem_ready) begin
        void'(exp_q.pop_front());
        k++;
      end
      cyc++;
      tick();
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic finish_seq(input logic wb, input logic [3:0] base, input logic s_exp);
    logic wb_on;
    wb_on = wb;
`ifndef LDM_WRITEBACK_EN
    wb_on = 1'b0;
`endif
    if (wb_on) begin
      chk("wb_valid",     32'(wb_valid),   32'd1);
      chk("wb_reg_nb",    32'(reg_nb),     32'(base));
      chk("wb_reg_valid", 32'(reg_valid),  32'd0);
      chk("wb_force",     32'(force_mode), 32'(s_exp));
      chk("wb_done",      32'(done),       32'd0);
      tick();
    end
    chk("done_wb_valid", 32'(wb_valid),  32'd0);
    chk("done_pulse",    32'(done),      32'd1);
    chk("done_busy",     32'(busy),      32'd1);
    chk("done_reg_valid",32'(reg_valid), 32'd0);
    tick();
    chk("post_done",       32'(done),       32'd0);
    chk("post_busy",       32'(busy),       32'd0);
    chk("post_force_mode", 32'(force_mode), 32'd0);
  endtask

  initial begin
    int hold;
    nreset    = 1'b0;
    start     = 1'b0;
    reg_list  = 16'h0000;
    base_nb   = 4'h0;
    wb_req    = 1'b0;
    s_bit     = 1'b0;
    mem_ready = 1'b0;
    abort     = 1'b0;
    #12;
    check_all_zero("reset");
    nreset = 1'b1;
    tick();
    check_all_zero("idle");

    // 0x8005 streaming: r0, r2, r15 back to back, then done.
    mem_ready = 1'b1;
    do_start(16'h8005, 4'h0, 1'b0, 1'b0);
    drain(0, 1'b0, hold);
    chk("stream_first_cycles", 32'(hold), 32'd1);
    finish_seq(1'b0, 4'h0, 1'b0);

    // 0x0003 with a 3-cycle stall on r0; start held high is ignored while busy.
    do_start(16'h0003, 4'h0, 1'b0, 1'b1);
    start    = 1'b1;
    reg_list = 16'hFFFF;
    drain(3, 1'b1, hold);
    start    = 1'b0;
    reg_list = 16'h0000;
    chk("stall_hold_cycles", 32'(hold), 32'd4);
    finish_seq(1'b0, 4'h0, 1'b1);

    // 0x0010 with base r13 writeback.
    mem_ready = 1'b1;
    do_start(16'h0010, 4'd13, 1'b1, 1'b0);
    drain(0, 1'b0, hold);
    finish_seq(1'b1, 4'd13, 1'b0);

    // Empty list becomes a single r15 transfer.
    do_start(16'h0000, 4'h0, 1'b0, 1'b0);
    drain(0, 1'b0, hold);
    finish_seq(1'b0, 4'h0, 1'b0);

    // Abort together with mem_ready on the second transfer of 0x00F0.
    mem_ready = 1'b1;
    do_start(16'h00F0, 4'd2, 1'b1, 1'b1);
    chk("abort_reg0", 32'(reg_nb), 32'd4);
    tick();
    chk("abort_reg1", 32'(reg_nb),   32'd5);
    chk("abort_idx1", 32'(xfer_idx), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_all_zero("abort");
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_idle",    32'(busy), 32'd0);
    exp_q.delete();

    // nreset mid-sequence clears every output before the next edge.
    do_start(16'h00FF, 4'h0, 1'b0, 1'b1);
    tick();
    tick();
    chk("pre_reset_busy", 32'(busy),     32'd1);
    chk("pre_reset_idx",  32'(xfer_idx), 32'd2);
    nreset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    #1;
    nreset = 1'b1;
    tick();
    chk("after_reset_busy", 32'(busy), 32'd0);
    exp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ldm_stm_sequencer
